// File: rtl/mc_arb_pkg.sv
// mc_arb_pkg: shared types and constants for the memory-port arbiter.
// Rev 1.0
`default_nettype none

package mc_arb_pkg;

  localparam int BLK_W  = 512;
  localparam int ADDR_W = 32;
  localparam int OFF_W  = 6;

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_D   = 2'd0,
    REQ_I   = 2'd1,
    REQ_DMA = 2'd2
  } req_id_t;

  function automatic logic [ADDR_W-1:0] blk_align(input logic [ADDR_W-1:0] a);
    return a & ~OFF_MASK;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_arbiter_if.sv
// mc_arbiter_if: requester and memory-port signals of the block arbiter.
// Rev 1.0
`default_nettype none

interface mc_arbiter_if;
  import mc_arb_pkg::*;

  logic              dMiss;
  logic              dEvict;
  logic [ADDR_W-1:0] dAddr;
  logic [BLK_W-1:0]  dBlkIn;
  logic              iMiss;
  logic [ADDR_W-1:0] iAddr;
  logic              dmaReq;
  logic              dmaWr;
  logic [ADDR_W-1:0] dmaAddr;
  logic [BLK_W-1:0]  dmaBlkIn;
  logic              memAck;
  logic [BLK_W-1:0]  memBlkIn;

  logic              memReq;
  logic              memWr;
  logic [ADDR_W-1:0] memAddr;
  logic [BLK_W-1:0]  memBlkOut;
  logic [BLK_W-1:0]  rdBlk;
  logic              dDataValid;
  logic              dEvictDone;
  logic              iDataValid;
  logic              dmaDone;
  logic [1:0]        grantId;
  logic              busy;
  logic              errTimeout;

  // The arbiter side; it masters the memory port.
  modport master (
    input  dMiss, dEvict, dAddr, dBlkIn, iMiss, iAddr,
           dmaReq, dmaWr, dmaAddr, dmaBlkIn, memAck, memBlkIn,
    output memReq, memWr, memAddr, memBlkOut, rdBlk,
           dDataValid, dEvictDone, iDataValid, dmaDone,
           grantId, busy, errTimeout
  );

  modport slave (
    output dMiss, dEvict, dAddr, dBlkIn, iMiss, iAddr,
           dmaReq, dmaWr, dmaAddr, dmaBlkIn, memAck, memBlkIn,
    input  memReq, memWr, memAddr, memBlkOut, rdBlk,
           dDataValid, dEvictDone, iDataValid, dmaDone,
           grantId, busy, errTimeout
  );

endinterface

`default_nettype wire

// File: rtl/mc_arbiter_rr_arb3.sv
// rr_arb3: combinational three-way round-robin pick starting after the last grant.
// Rev 1.0
`default_nettype none

module rr_arb3
  import mc_arb_pkg::*;
(
  input  logic [2:0] req,
  input  req_id_t    last,
  output logic [2:0] gnt,
  output req_id_t    gid
);

  req_id_t first;
  req_id_t second;
  req_id_t third;

  always_comb begin
    first  = REQ_D;
    second = REQ_I;
    third  = REQ_DMA;
    case (last)
      REQ_D: begin
        first  = REQ_I;
        second = REQ_DMA;
        third  = REQ_D;
      end
      REQ_I: begin
        first  = REQ_DMA;
        second = REQ_D;
        third  = REQ_I;
      end
      default: ;
    endcase

    gid = third;
    if (req[first])
      gid = first;
    else if (req[second])
      gid = second;

    gnt = (|req) ? (3'b001 << gid) : 3'b000;
  end

endmodule

`default_nettype wire

// File: rtl/mc_arbiter.sv
// mc_arbiter: arbitrates 512-bit block loads/write-backs from D-cache, I-cache and DMA onto one memory port.
// Rev 1.0
`default_nettype none

module mc_arbiter
  import mc_arb_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  mc_arbiter_if.master  bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  arb_state_t        state;
  arb_state_t        state_nxt;
  req_id_t           gid;
  req_id_t           last_grant;
  req_id_t           pick;
  logic [2:0]        req_vec;
  logic [2:0]        gnt;
  logic              grant_any;
  logic              pick_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [BLK_W-1:0]  sel_wdata;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [BLK_W-1:0]  wdata_q;
  logic [BLK_W-1:0]  rd_blk;
  logic [CNT_W-1:0]  wd_cnt;
  logic              wd_hit;
  logic              err;
  logic              d_valid;
  logic              d_evict_done;
  logic              i_valid;
  logic              dma_done;

  assign req_vec   = {bus.dmaReq, bus.iMiss, bus.dMiss | bus.dEvict};
  assign grant_any = |gnt;
  assign wd_hit    = (wd_cnt == CNT_W'(TIMEOUT - 1));

  rr_arb3 u_rr (
    .req  (req_vec),
    .last (last_grant),
    .gnt  (gnt),
    .gid  (pick)
  );

  // A pending write-back beats the refill; the refill re-arbitrates afterwards.
  always_comb begin
    pick_wr   = 1'b0;
    sel_addr  = bus.dAddr;
    sel_wdata = bus.dBlkIn;
    case (pick)
      REQ_D:   pick_wr = bus.dEvict;
      REQ_I: begin
        sel_addr  = bus.iAddr;
        sel_wdata = '0;
      end
      REQ_DMA: begin
        pick_wr   = bus.dmaWr;
        sel_addr  = bus.dmaAddr;
        sel_wdata = bus.dmaBlkIn;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    d_valid      = 1'b0;
    d_evict_done = 1'b0;
    i_valid      = 1'b0;
    dma_done     = 1'b0;
    case (state)
      IDLE: if (grant_any) state_nxt = BUSY;
      BUSY: if (bus.memAck || wd_hit) state_nxt = RESP;
      RESP: begin
        state_nxt = IDLE;
        case (gid)
          REQ_D: begin
            d_evict_done = op_wr;
            d_valid      = !op_wr;
          end
          REQ_I:   i_valid  = 1'b1;
          REQ_DMA: dma_done = 1'b1;
          default: ;
        endcase
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gid        <= REQ_D;
      last_grant <= REQ_DMA;
      op_wr      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_blk     <= '0;
      wd_cnt     <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            gid     <= pick;
            op_wr   <= pick_wr;
            addr_q  <= blk_align(sel_addr);
            wdata_q <= sel_wdata;
            wd_cnt  <= '0;
          end
        end
        BUSY: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (bus.memAck) begin
            if (!op_wr)
              rd_blk <= bus.memBlkIn;
            last_grant <= gid;
          end else if (wd_hit) begin
            // A timed-out requester still rotates priority so it cannot starve others.
            err        <= 1'b1;
            last_grant <= gid;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.memReq     = (state == BUSY);
  assign bus.memWr      = (state == BUSY) && op_wr;
  assign bus.memAddr    = addr_q;
  assign bus.memBlkOut  = wdata_q;
  assign bus.rdBlk      = rd_blk;
  assign bus.dDataValid = d_valid;
  assign bus.dEvictDone = d_evict_done;
  assign bus.iDataValid = i_valid;
  assign bus.dmaDone    = dma_done;
  assign bus.grantId    = gid;
  assign bus.busy       = (state != IDLE);
  assign bus.errTimeout = err;

endmodule

`default_nettype wire
